// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_ctrl
//  Purpose  : Owner of the architectural HI/LO registers and sequencer for
//             the shared multi-cycle multiply/divide engine. Launches engine
//             operations, commits results, stalls HI/LO consumers while an
//             operation is in flight, and handles cancel and engine timeout.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        cancel,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  input  logic        eng_done,
  input  logic [31:0] eng_hi,
  input  logic [31:0] eng_lo,
  output logic        timeout
);

  // Request opcodes as presented by the EX stage
  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;
  localparam logic [3:0] c_OP_MFHI  = 4'd7;
  localparam logic [3:0] c_OP_MFLO  = 4'd8;

  // Watchdog sized to hold TIMEOUT; abort is decided on its last count
  localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
  localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

  // BUSY: in-flight result will commit; DRAIN: in-flight result is discarded
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [1:0]          op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic                start_q, start_d;
  logic                timeout_q, timeout_d;
  logic [c_WD_W-1:0]   wdog_q, wdog_d;

  logic                w_acc;
  logic                w_is_md;
  logic                w_div_zero;
  logic [1:0]          w_eng_op;

  assign w_acc = req_valid & ~flush;

  // Decode engine-class requests and the divide-by-zero case that never launches
  always_comb begin
    w_is_md    = 1'b0;
    w_div_zero = 1'b0;
    w_eng_op   = 2'd0;
    case (req_op)
      c_OP_MULT:  begin w_is_md = 1'b1; w_eng_op = 2'd0; end
      c_OP_MULTU: begin w_is_md = 1'b1; w_eng_op = 2'd1; end
      c_OP_DIV:   begin w_is_md = 1'b1; w_eng_op = 2'd2; w_div_zero = (req_b == 32'd0); end
      c_OP_DIVU:  begin w_is_md = 1'b1; w_eng_op = 2'd3; w_div_zero = (req_b == 32'd0); end
      default:    ;
    endcase
  end

  // Next-state, register updates and combinational stall/rdata
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    wdog_d    = wdog_q;
    stall     = 1'b0;
    rdata     = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (w_acc) begin
          if (w_is_md) begin
            if (!w_div_zero) begin
              op_d    = w_eng_op;
              a_d     = req_a;
              b_d     = req_b;
              start_d = 1'b1;
              wdog_d  = '0;
              state_d = S_BUSY;
            end
          end else begin
            case (req_op)
              c_OP_MTHI: hi_d  = req_a;
              c_OP_MTLO: lo_d  = req_a;
              c_OP_MFHI: rdata = hi_q;
              c_OP_MFLO: rdata = lo_q;
              default:   ;
            endcase
          end
        end
      end
      S_BUSY, S_DRAIN: begin
        stall  = w_acc;
        wdog_d = wdog_q + c_WD_ONE;
        if (eng_done) begin
          // A cancel arriving with done still discards the result
          if ((state_q == S_BUSY) && !cancel) begin
            hi_d = eng_hi;
            lo_d = eng_lo;
          end
          state_d = S_IDLE;
        end else if (wdog_q == c_WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cancel) begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      op_q      <= 2'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign eng_start = start_q;
  assign eng_op    = op_q;
  assign eng_a     = a_q;
  assign eng_b     = b_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_ctrl
//  Purpose  : Self-checking bench for hilo_ctrl: directed scenarios with
//             literal expectations plus a per-cycle reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hilo_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush, cancel;
  logic        stall;
  logic [31:0] rdata, hi, lo;
  logic        eng_start;
  logic [1:0]  eng_op;
  logic [31:0] eng_a, eng_b;
  logic        eng_done;
  logic [31:0] eng_hi, eng_lo;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  hilo_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .cancel(cancel),
    .stall(stall), .rdata(rdata), .hi(hi), .lo(lo),
    .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_hi(eng_hi), .eng_lo(eng_lo), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  // Reference model: an op is "in flight" from launch until its done pulse,
  // a cancel marks it as not-to-commit, and it expires TMO cycles after eng_start.
  initial begin : model
    int          cyc;
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [1:0]  m_op;
    bit          m_busy, m_keep, m_start, m_tmo, acc;
    int          m_launch;
    logic [31:0] exp_rd;
    cyc = 0;
    m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0;
    m_busy = 0; m_keep = 0; m_start = 0; m_tmo = 0; m_launch = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0;
        m_busy = 0; m_keep = 0; m_start = 0; m_tmo = 0;
      end else begin
        acc    = req_valid && !flush;
        exp_rd = 32'd0;
        if (acc && !m_busy && req_op == 4'd7) exp_rd = m_hi;
        if (acc && !m_busy && req_op == 4'd8) exp_rd = m_lo;
        chk("model_stall", {31'd0, stall}, {31'd0, acc && m_busy});
        chk("model_rdata", rdata, exp_rd);
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
        chk("model_eng_start", {31'd0, eng_start}, {31'd0, m_start});
        chk("model_timeout", {31'd0, timeout}, {31'd0, m_tmo});
        if (m_busy) begin
          chk("model_eng_op", {30'd0, eng_op}, {30'd0, m_op});
          chk("model_eng_a", eng_a, m_a);
          chk("model_eng_b", eng_b, m_b);
        end
        m_start = 0;
        m_tmo   = 0;
        if (m_busy) begin
          if (eng_done) begin
            if (m_keep && !cancel) begin m_hi = eng_hi; m_lo = eng_lo; end
            m_busy = 0;
          end else begin
            if (cancel) m_keep = 0;
            if (cyc - m_launch == TMO - 1) begin m_busy = 0; m_tmo = 1; end
          end
        end else if (acc) begin
          if (req_op >= 4'd1 && req_op <= 4'd4) begin
            if (!(req_op >= 4'd3 && req_b == 0)) begin
              m_busy = 1; m_keep = 1; m_start = 1; m_launch = cyc + 1;
              m_op = 2'(req_op - 4'd1); m_a = req_a; m_b = req_b;
            end
          end else if (req_op == 4'd5) m_hi = req_a;
          else if (req_op == 4'd6) m_lo = req_a;
        end
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    rst = 1'b1; flush = 0; cancel = 0; eng_done = 0; eng_hi = 0; eng_lo = 0;
    drive(0, 0, 0, 0);
    nxt(); nxt();
    rst = 1'b0;
    #1;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_stall", {31'd0, stall}, 0); chk("rst_start", {31'd0, eng_start}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    drive(1, 8, 0, 0); #1 chk("rst_mflo", rdata, 0);

    // MTLO then MFLO on consecutive cycles
    nxt(); drive(1, 6, 32'h5a, 0);
    nxt(); drive(1, 8, 0, 0); #1 chk("mtlo_mflo", rdata, 32'h5a);

    // Flushed MTHI has no effect
    nxt(); drive(1, 5, 32'habc, 0); flush = 1;
    nxt(); flush = 0; drive(1, 7, 0, 0); #1 chk("flush_ignored", rdata, 0);

    // MULT with a stalled MFLO behind it
    nxt(); drive(1, 1, 32'hFFFFFFFF, 2); #1 chk("mult_no_stall", {31'd0, stall}, 0);
    nxt(); drive(1, 8, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mult_start", {31'd0, eng_start}, (k == 0) ? 32'd1 : 32'd0);
      chk("mult_stall", {31'd0, stall}, 1);
      nxt();
    end
    eng_done = 1; eng_hi = 32'hFFFFFFFF; eng_lo = 32'hFFFFFFFE;
    #1 chk("mult_done_stall", {31'd0, stall}, 1); chk("mult_lo_before", lo, 32'h5a);
    nxt(); eng_done = 0;
    #1 chk("mult_release", {31'd0, stall}, 0); chk("mult_rdata", rdata, 32'hFFFFFFFE);
    chk("mult_hi", hi, 32'hFFFFFFFF);

    // DIVU by zero: no launch, no stall
    nxt(); drive(1, 4, 7, 0); #1 chk("divz_stall", {31'd0, stall}, 0);
    nxt(); drive(1, 7, 0, 0);
    #1 chk("divz_start", {31'd0, eng_start}, 0); chk("divz_mfhi_stall", {31'd0, stall}, 0);
    chk("divz_mfhi", rdata, 32'hFFFFFFFF);

    // Back-to-back: second MULT waits, then launches at done+2
    nxt(); drive(1, 2, 3, 5);
    nxt(); drive(1, 1, 2, 3); #1 chk("b2b_stall", {31'd0, stall}, 1);
    nxt(); eng_done = 1; eng_hi = 0; eng_lo = 15;
    nxt(); eng_done = 0; #1 chk("b2b_accept", {31'd0, stall}, 0); chk("b2b_lo1", lo, 15);
    nxt(); drive(0, 0, 0, 0); #1 chk("b2b_start", {31'd0, eng_start}, 1); chk("b2b_a", eng_a, 2);
    nxt(); eng_done = 1; eng_hi = 0; eng_lo = 6;
    nxt(); eng_done = 0; #1 chk("b2b_lo2", lo, 6);

    // Cancel: result discarded, stalled MTHI then completes
    drive(1, 2, 10, 10);
    nxt(); drive(1, 5, 32'h1234, 0); #1 chk("cancel_stall", {31'd0, stall}, 1);
    nxt(); cancel = 1;
    nxt(); cancel = 0;
    nxt(); eng_done = 1; eng_hi = 32'hDEAD; eng_lo = 32'hBEEF;
    #1 chk("drain_stall", {31'd0, stall}, 1);
    nxt(); eng_done = 0; #1 chk("cancel_release", {31'd0, stall}, 0);
    chk("cancel_hi", hi, 0); chk("cancel_lo", lo, 6);
    nxt(); drive(0, 0, 0, 0); #1 chk("mthi_after", hi, 32'h1234);

    // cancel and done together: discard, idle next cycle
    drive(1, 1, 1, 1);
    nxt(); drive(0, 0, 0, 0);
    nxt(); cancel = 1; eng_done = 1; eng_hi = 32'h77; eng_lo = 32'h99;
    nxt(); cancel = 0; eng_done = 0; drive(1, 8, 0, 0);
    #1 chk("cd_stall", {31'd0, stall}, 0); chk("cd_rdata", rdata, 6);

    // Engine never responds
    nxt(); drive(1, 3, 100, 7);
    nxt(); drive(1, 7, 0, 0);
    for (int k = 0; k < TMO; k++) begin
      #1;
      chk("tmo_quiet", {31'd0, timeout}, 0);
      chk("tmo_stall", {31'd0, stall}, 1);
      chk("tmo_start", {31'd0, eng_start}, (k == 0) ? 32'd1 : 32'd0);
      nxt();
    end
    #1 chk("tmo_pulse", {31'd0, timeout}, 1); chk("tmo_release", {31'd0, stall}, 0);
    chk("tmo_rdata", rdata, 32'h1234);
    nxt(); drive(0, 0, 0, 0); eng_done = 1; eng_hi = 32'h5555; eng_lo = 32'h6666;
    #1 chk("tmo_one_cycle", {31'd0, timeout}, 0);
    nxt(); eng_done = 0; #1 chk("late_hi", hi, 32'h1234); chk("late_lo", lo, 6);

    // Reset mid-operation
    drive(1, 1, 5, 5);
    nxt(); drive(0, 0, 0, 0); #1 chk("rm_start", {31'd0, eng_start}, 1);
    rst = 1; #1;
    chk("rm_hi", hi, 0); chk("rm_lo", lo, 0); chk("rm_start0", {31'd0, eng_start}, 0);
    nxt(); rst = 0;
    nxt(); eng_done = 1; eng_hi = 32'h11; eng_lo = 32'h22;
    nxt(); eng_done = 0; #1 chk("rm_done_ignored", lo, 0);

    nxt(); nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer and owner of the architectural HI/LO registers. It sits beside the EX-stage ALU and shares one multi-cycle multiply/divide engine among MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO. It launches engine operations, commits results into HI/LO, and raises pipeline stall when a HI/LO consumer or a second mul/div meets an operation still in flight. It also handles squash of in-flight operations and engine timeout.

## Interface
Parameters:
- TIMEOUT, 64: max cycles from eng_start to eng_done before abort (>=2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  EX stage presents a HI/LO-class instruction this cycle.
- req_op  in  4  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=MFHI 8=MFLO; other codes are no-op.
- req_a, req_b  in  32 each  rs/rt operands (req_a is write data for MTHI/MTLO).
- flush  in  1  squash the current EX instruction; request ignored this cycle.
- cancel  in  1  squash the instruction that issued the in-flight engine op.
- stall  out  1  combinational; hold EX and earlier stages.
- rdata  out  32  combinational MFHI/MFLO result.
- hi, lo  out  32 each  architectural registers.
- eng_start  out  1  registered one-cycle launch pulse.
- eng_op  out  2  0=MULT 1=MULTU 2=DIV 3=DIVU; held from launch until commit or discard.
- eng_a, eng_b  out  32 each  operands, held like eng_op.
- eng_done  in  1  one-cycle completion pulse from engine.
- eng_hi, eng_lo  in  32 each  engine result, valid with eng_done.
- timeout  out  1  registered one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, BUSY (result will commit), DRAIN (result will be discarded).
- IDLE, accepted request (req_valid & ~flush):
  - MULT/MULTU/DIV/DIVU with nonzero divisor: latch eng_op/eng_a/eng_b, eng_start=1 next cycle, go to BUSY, clear watchdog. The issuing instruction is not stalled.
  - DIV/DIVU with req_b==0: no launch; HI/LO unchanged; stay IDLE. Exception is raised by the ALU.
  - MTHI/MTLO: hi/lo <= req_a at edge.
  - MFHI/MFLO: rdata = hi/lo.
- BUSY/DRAIN: any accepted request drives stall=1, with no side effects until state returns to IDLE.
- BUSY, eng_done: {hi,lo} <= {eng_hi,eng_lo}; go to IDLE.
- BUSY, cancel: go to DRAIN. If cancel and eng_done occur in the same cycle, cancel wins: discard and go to IDLE.
- DRAIN, eng_done: discard result and go to IDLE.
- Watchdog counts cycles in BUSY/DRAIN. On reaching TIMEOUT with no eng_done: timeout pulse, HI/LO unchanged, go to IDLE. A late eng_done while in IDLE is ignored.
- flush has no effect on an op already launched; only cancel does.
- rdata = 0 when no MF request is accepted this cycle.

## Timing
- Reset values: state IDLE; hi, lo, eng_a, eng_b = 0; eng_op = 0; eng_start = 0; timeout = 0; watchdog = 0. stall and rdata evaluate to 0.
- Launch latency: request at cycle N, eng_start high at cycle N+1 only.
- Commit: eng_done at cycle M updates hi/lo at the M edge. A stalled MFHI sees the new value and stall drops in cycle M+1.
- Back-to-back: a second MULT stalled behind the first launches eng_start at cycle M+2.
- MTHI then MFHI on consecutive cycles: the MFHI reads the MTHI data, since the register is written at the edge.
- Reset mid-operation returns immediately to IDLE. The engine is reset by the same rst.

## Test plan
- Reset: after reset, hi=lo=0, stall=0, eng_start=0; MFLO returns rdata=0.
- MULT a=0xFFFFFFFF b=2; engine returns done after 5 cycles with hi=0xFFFFFFFF lo=0xFFFFFFFE. Require eng_start exactly one cycle, hi/lo updated at the done edge. A MFLO issued during BUSY stalls until done+1, then reads 0xFFFFFFFE.
- DIVU a=7 b=0 -> no eng_start, hi/lo unchanged, no stall on a following MFHI.
- MULTU issued, then cancel two cycles later, then eng_done -> hi/lo unchanged. A stalled MTHI 0x1234 is released and hi=0x1234.
- cancel and eng_done asserted in the same cycle -> result discarded, state IDLE next cycle.
- Engine never responds -> timeout pulses exactly at TIMEOUT cycles after launch, stall drops, hi/lo unchanged. A late eng_done is ignored.
